// File: rtl/ex_stage_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ex_stage_pipe                                          |
// | Description : Registered execute stage. ALU, branch/jump target,     |
// |               link data, EX/MEM output register with valid/ready,    |
// |               optional iterative shift-add multiplier.               |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ex_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 5,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [4:0]      alu_op,
  input  logic [3:0]      jump_type,
  input  logic            reg_wrenable,
  input  logic            mem_wrenable,
  input  logic            mem_to_reg,
  input  logic [4:0]      write_reg,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic            out_taken,
  output logic [XLEN-1:0] alu_res,
  output logic [XLEN-1:0] write_data,
  output logic            out_reg_wrenable,
  output logic            out_mem_wrenable,
  output logic            out_mem_to_reg,
  output logic [4:0]      out_write_reg
);

  localparam int c_shw = $clog2(XLEN);
  localparam int c_cw  = $clog2(XLEN + 1);

  localparam logic [4:0] c_op_add  = 5'd0;
  localparam logic [4:0] c_op_sub  = 5'd1;
  localparam logic [4:0] c_op_and  = 5'd2;
  localparam logic [4:0] c_op_or   = 5'd3;
  localparam logic [4:0] c_op_xor  = 5'd4;
  localparam logic [4:0] c_op_sll  = 5'd5;
  localparam logic [4:0] c_op_srl  = 5'd6;
  localparam logic [4:0] c_op_sra  = 5'd7;
  localparam logic [4:0] c_op_slt  = 5'd8;
  localparam logic [4:0] c_op_sltu = 5'd9;
  localparam logic [4:0] c_op_mul  = 5'd16;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_acc;
  logic [c_cw-1:0]   r_cnt;

  logic [XLEN-1:0]   w_op2;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN-1:0]   w_wd;
  logic [XLEN-1:0]   w_acc_nxt;
  logic [PC_W-1:0]   w_pc_tgt;
  logic [PC_W-1:0]   w_pc_inc;
  logic [c_shw-1:0]  w_shamt;
  logic              w_taken;
  logic              w_accept;
  logic              w_start_mul;
  logic              w_mul_last;

  assign w_op2       = alu_src ? imm : rd2;
  assign w_shamt     = w_op2[c_shw-1:0];
  assign in_ready    = (r_state == S_IDLE) & (~out_valid | out_ready) & ~flush;
  assign w_accept    = in_valid & in_ready;
  assign w_start_mul = w_accept & (alu_op == c_op_mul) & (MUL_EN != 0);
  assign w_mul_last  = (r_state == S_MUL_BUSY) & (r_cnt == c_cw'(1));
  assign w_acc_nxt   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Single-cycle ALU; MUL and undefined codes yield 0 here (MUL result comes from the iterator)
  always_comb begin
    w_alu = '0;
    case (alu_op)
      c_op_add:  w_alu = rd1 + w_op2;
      c_op_sub:  w_alu = rd1 - w_op2;
      c_op_and:  w_alu = rd1 & w_op2;
      c_op_or:   w_alu = rd1 | w_op2;
      c_op_xor:  w_alu = rd1 ^ w_op2;
      c_op_sll:  w_alu = rd1 << w_shamt;
      c_op_srl:  w_alu = rd1 >> w_shamt;
      c_op_sra:  w_alu = $unsigned($signed(rd1) >>> w_shamt);
      c_op_slt:  w_alu = {{(XLEN-1){1'b0}}, ($signed(rd1) < $signed(w_op2))};
      c_op_sltu: w_alu = {{(XLEN-1){1'b0}}, (rd1 < w_op2)};
      default:   w_alu = '0;
    endcase
  end

  // Control-transfer target, taken flag and link/store data
  always_comb begin
    w_pc_inc = in_pc + PC_W'(1);
    w_pc_tgt = (jump_type[1:0] == 2'b11) ? w_alu[PC_W-1:0] : (in_pc + imm[PC_W-1:0]);
    w_taken  = jump_type[1] | (jump_type[2] & ((rd1 == rd2) ^ jump_type[3]));
    w_wd     = jump_type[1] ? {{(XLEN-PC_W){1'b0}}, w_pc_inc} : rd2;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: enter busy on MUL accept, leave after the last iteration or on flush
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_start_mul) w_state_nxt = S_MUL_BUSY;
      S_MUL_BUSY: if (w_mul_last)  w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // Output register and multiplier datapath: accept, iterate, or drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      out_pc           <= '0;
      out_taken        <= 1'b0;
      alu_res          <= '0;
      write_data       <= '0;
      out_reg_wrenable <= 1'b0;
      out_mem_wrenable <= 1'b0;
      out_mem_to_reg   <= 1'b0;
      out_write_reg    <= '0;
      r_mcand          <= '0;
      r_mplier         <= '0;
      r_acc            <= '0;
      r_cnt            <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      out_pc           <= w_pc_tgt;
      out_taken        <= w_taken;
      alu_res          <= w_alu;
      write_data       <= w_wd;
      out_reg_wrenable <= reg_wrenable;
      out_mem_wrenable <= mem_wrenable;
      out_mem_to_reg   <= mem_to_reg;
      out_write_reg    <= write_reg;
      // A multiply only becomes visible once the iteration completes
      out_valid        <= ~w_start_mul;
      if (w_start_mul) begin
        r_mcand  <= rd1;
        r_mplier <= w_op2;
        r_acc    <= '0;
        r_cnt    <= c_cw'(XLEN);
      end
    end else if (r_state == S_MUL_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - c_cw'(1);
      if (w_mul_last) begin
        alu_res   <= w_acc_nxt;
        out_valid <= 1'b1;
      end
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ex_stage_pipe                                       |
// | Description : Self-checking bench for ex_stage_pipe with a           |
// |               behavioural reference model.                           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_ex_stage_pipe;
  localparam int XLEN = 32;
  localparam int PC_W = 5;

  logic        clk;
  logic        rst_n, flush, in_valid, in_ready, alu_src, out_valid, out_ready, out_taken;
  logic [4:0]  in_pc, out_pc, alu_op, write_reg, out_write_reg;
  logic [31:0] rd1, rd2, imm, alu_res, write_data;
  logic [3:0]  jump_type;
  logic        reg_wrenable, mem_wrenable, mem_to_reg;
  logic        out_reg_wrenable, out_mem_wrenable, out_mem_to_reg;

  ex_stage_pipe #(.XLEN(XLEN), .PC_W(PC_W), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .rd1(rd1), .rd2(rd2), .imm(imm), .alu_src(alu_src), .alu_op(alu_op),
    .jump_type(jump_type), .reg_wrenable(reg_wrenable), .mem_wrenable(mem_wrenable),
    .mem_to_reg(mem_to_reg), .write_reg(write_reg), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_taken(out_taken), .alu_res(alu_res),
    .write_data(write_data), .out_reg_wrenable(out_reg_wrenable),
    .out_mem_wrenable(out_mem_wrenable), .out_mem_to_reg(out_mem_to_reg),
    .out_write_reg(out_write_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  pc;
    logic        taken;
    logic [31:0] wd;
    logic [7:0]  side;
  } exp_t;

  // Reference ALU computed from the operation definitions with plain arithmetic
  function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
    int sh;
    longint unsigned p;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return 32'(int'(a) >>> sh);
      8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      16: begin p = longint'(a) * longint'(b); return 32'(p); end
      default: return 32'd0;
    endcase
  endfunction

  // Expected stage result for the op currently on the inputs
  function automatic exp_t model();
    exp_t e;
    logic [31:0] op2, pcalu;
    op2     = alu_src ? imm : rd2;
    e.alu   = ref_alu(int'(alu_op), rd1, op2);
    pcalu   = (alu_op == 5'd16) ? 32'd0 : e.alu;
    if (jump_type[1:0] == 2'b11) e.pc = pcalu[4:0];
    else                         e.pc = 5'((int'(in_pc) + int'(imm[4:0])) % 32);
    e.taken = jump_type[1] | (jump_type[2] & ((rd1 == rd2) ^ jump_type[3]));
    e.wd    = jump_type[1] ? 32'((int'(in_pc) + 1) % 32) : rd2;
    e.side  = {reg_wrenable, mem_wrenable, mem_to_reg, write_reg};
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(string tag, exp_t e);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".alu"},   64'(alu_res), 64'(e.alu));
    chk({tag, ".pc"},    64'(out_pc), 64'(e.pc));
    chk({tag, ".taken"}, 64'(out_taken), 64'(e.taken));
    chk({tag, ".wd"},    64'(write_data), 64'(e.wd));
    chk({tag, ".side"},  64'({out_reg_wrenable, out_mem_wrenable, out_mem_to_reg, out_write_reg}),
        64'(e.side));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int op, logic [31:0] a, logic [31:0] b, logic [31:0] im,
                        logic src, logic [3:0] jt, logic [4:0] pc);
    alu_op       = 5'(op);
    rd1          = a;
    rd2          = b;
    imm          = im;
    alu_src      = src;
    jump_type    = jt;
    in_pc        = pc;
    reg_wrenable = 1'($urandom);
    mem_wrenable = 1'($urandom);
    mem_to_reg   = 1'($urandom);
    write_reg    = 5'($urandom);
  endtask

  // From the accept edge: XLEN-1 further busy cycles, then the product appears
  task automatic mul_wait(string tag, exp_t e);
    for (int k = 0; k < XLEN; k++) begin
      chk({tag, ".busy"}, 64'({out_valid, in_ready}), 64'd0);
      step();
    end
    chk_out(tag, e);
  endtask

  task automatic run_mul(string tag, logic [31:0] a, logic [31:0] b, logic [31:0] im, logic src);
    exp_t e;
    set_op(16, a, b, im, src, 4'($urandom), 5'($urandom));
    e = model();
    in_valid = 1'b1;
    #1 chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    mul_wait(tag, e);
  endtask

  exp_t ea, eb, ec, e;
  int   op;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.alu",   64'(alu_res), 64'd0);
    chk("rst.pc",    64'(out_pc), 64'd0);
    rst_n = 1'b1;

    // ADD with immediate
    set_op(0, 5, 32'h1234, 3, 1, 4'b0000, 5'd4);
    e = model(); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk_out("add", e);
    chk("add.const", 64'(alu_res), 64'd8);
    chk("add.wd", 64'(write_data), 64'h1234);
    step();
    chk("add.drain", 64'(out_valid), 64'd0);

    // jalr
    set_op(0, 30, 0, 4, 1, 4'b0011, 5'd7);
    e = model(); in_valid = 1'b1;
    step();
    chk_out("jalr", e);
    chk("jalr.const", 64'({alu_res, out_pc, out_taken, write_data}),
        {32'd34, 5'd2, 1'b1, 32'd8});

    // jal with PC wrap, back to back
    set_op(0, 0, 0, 1, 1, 4'b0010, 5'd31);
    e = model();
    step();
    chk_out("jal", e);
    chk("jal.const", 64'({out_pc, write_data}), {5'd0, 32'd0});

    // BNE-style branch, equal then unequal
    set_op(1, 9, 9, 0, 0, 4'b1100, 5'd3);
    e = model();
    step();
    chk_out("bne.eq", e);
    chk("bne.eq.t", 64'(out_taken), 64'd0);
    set_op(1, 9, 10, 0, 0, 4'b1100, 5'd3);
    e = model();
    step();
    chk_out("bne.ne", e);
    chk("bne.ne.t", 64'(out_taken), 64'd1);

    // Random single-cycle ops streamed back to back
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 31));
      if (op == 16) op = 0;
      set_op(op, $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom), 5'($urandom));
      if (i % 5 == 0) rd2 = rd1;
      e = model();
      #1 chk("rnd.rdy", 64'(in_ready), 64'd1);
      step();
      chk_out("rnd", e);
    end
    in_valid = 1'b0;
    step();
    chk("rnd.drain", 64'(out_valid), 64'd0);

    // Back-pressure: first result held, followers wait, then drain in order
    set_op(0, $urandom, $urandom, $urandom, 1, 4'b0000, 5'($urandom));
    ea = model(); in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    set_op(0, $urandom, $urandom, $urandom, 0, 4'b0100, 5'($urandom));
    eb = model();
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp.rdy0", 64'(in_ready), 64'd0);
      chk_out("bp.hold", ea);
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp.rdy1", 64'(in_ready), 64'd1);
    step();
    chk_out("bp.B", eb);
    set_op(0, $urandom, $urandom, $urandom, 1, 4'b0010, 5'($urandom));
    ec = model();
    step();
    chk_out("bp.C", ec);
    in_valid = 1'b0;
    step();
    chk("bp.drain", 64'(out_valid), 64'd0);

    // Directed multiply 7*6
    run_mul("mul76", 7, 6, 32'hFFFF, 0);
    chk("mul76.const", 64'(alu_res), 64'd42);
    step();
    chk("mul76.drain", 64'(out_valid), 64'd0);

    // Random multiplies
    for (int i = 0; i < 3; i++) run_mul("mulr", $urandom, $urandom, $urandom, 1'($urandom));

    // Multiply entry blocked while a result is held, then accepted as it drains
    set_op(2, $urandom, $urandom, $urandom, 0, 4'b0000, 5'($urandom));
    ea = model(); in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    set_op(16, $urandom, $urandom, 0, 0, 4'b0011, 5'($urandom));
    e = model();
    #1 chk("mulblk.rdy0", 64'(in_ready), 64'd0);
    step();
    chk_out("mulblk.hold", ea);
    out_ready = 1'b1;
    #1 chk("mulblk.rdy1", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    mul_wait("mulblk", e);

    // Flush at busy cycle 10 discards the multiply
    set_op(16, 7, 6, 0, 0, 4'b0000, 5'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1 chk("flush.rdy", 64'(in_ready), 64'd1);
    for (int k = 0; k < 40; k++) begin
      chk("flush.novalid", 64'(out_valid), 64'd0);
      step();
    end

    // Flush drops a held single-cycle result
    out_ready = 1'b0;
    set_op(3, $urandom, $urandom, $urandom, 1, 4'b0000, 5'($urandom));
    e = model(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_out("flhold", e);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flhold.valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;

    // Reset in the middle of a multiply clears everything
    set_op(0, 32'hDEAD, 32'hBEEF, 32'h55, 1, 4'b0010, 5'd9);
    in_valid = 1'b1;
    step();
    set_op(16, 7, 6, 0, 0, 4'b0010, 5'd9);
    reg_wrenable = 1'b1; write_reg = 5'd17;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    step();
    chk("rstmul.outs", 64'({out_valid, out_taken, out_pc, out_reg_wrenable, out_mem_wrenable,
                            out_mem_to_reg, out_write_reg}), 64'd0);
    chk("rstmul.data", {alu_res, write_data}, 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      chk("rstmul.novalid", 64'(out_valid), 64'd0);
      step();
    end

    // Stage still works after reset
    set_op(7, 32'h8000_0010, 0, 4, 1, 4'b0000, 5'd2);
    e = model(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_out("post", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised, registered execute stage for the pipelined CPU. It computes ALU results, branch and jump targets, and link write-data. Results are held in an EX/MEM output register behind a valid/ready handshake. An optional iterative shift-add multiplier introduces multi-cycle operations with stall back-pressure toward decode.

Parameters:
XLEN, 32, datapath width of operands and results
PC_W, 5, program-counter width (word-addressed)
MUL_EN, 1, 1 = iterative MUL supported; 0 = MUL op returns 0 in one cycle

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous squash of held and in-flight op
in_valid  in  1  upstream op present
in_ready  out  1  stage can accept op this cycle
in_pc  in  PC_W  PC of op
rd1, rd2  in  XLEN  register operands
imm  in  XLEN  immediate
alu_src  in  1  1 = op2 is imm, 0 = op2 is rd2
alu_op  in  5  operation code (see Behaviour)
jump_type  in  4  [1]=link, [1:0]==11 jalr, [2]=cond branch, [3]=invert compare
reg_wrenable, mem_wrenable, mem_to_reg  in  1 each  sideband, registered through
write_reg  in  5  destination register, registered through
out_valid  out  1  output register holds valid result
out_ready  in  1  downstream accepts result
out_pc  out  PC_W  target PC
out_taken  out  1  control transfer taken
alu_res  out  XLEN  ALU/MUL result
write_data  out  XLEN  store data or link value
out_reg_wrenable, out_mem_wrenable, out_mem_to_reg  out  1 each  registered sideband
out_write_reg  out  5  registered sideband

Behaviour:
- Reset (rst_n=0 at an edge): all outputs and state are 0, FSM=IDLE, out_valid=0. Reset has priority over flush, which has priority over accept.
- alu_op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 16 MUL (low XLEN bits). Undefined codes give result 0. Shift amount = op2[$clog2(XLEN)-1:0].
- op2 = alu_src ? imm : rd2. All arithmetic wraps modulo 2^XLEN.
- out_pc: jalr (jump_type[1:0]==11) gives alu_res[PC_W-1:0]; otherwise (in_pc + imm[PC_W-1:0]) mod 2^PC_W.
- out_taken = jump_type[1] | (jump_type[2] & ((rd1==rd2) ^ jump_type[3])).
- write_data = jump_type[1] ? zero-extended (in_pc+1) mod 2^PC_W : rd2.
- Accept occurs when in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
- Single-cycle op: the result is loaded at the accept edge, and out_valid=1 from the next cycle. Back-to-back accepts give one result per cycle.
- Output hold: while out_valid & !out_ready, all out_* signals are stable. Result is consumed at the edge where out_valid & out_ready. out_valid drops unless a new op is accepted at the same edge.
- FSM: IDLE, MUL_BUSY.
  - IDLE to MUL_BUSY on accept of MUL with MUL_EN=1. This latches multiplicand=rd1, multiplier=op2, acc=0, cnt=XLEN, and all sideband/control results.
  - MUL_BUSY: each cycle, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt -= 1.
  - At the edge where cnt==1, the final acc is written to alu_res, out_valid goes to 1, and the FSM returns to IDLE.
  - Latency is XLEN cycles from the accept edge to out_valid. in_ready=0 throughout MUL_BUSY.
  - Entry into MUL_BUSY requires the output register to be free or draining at the accept edge. The existing result is released normally.
- MUL with MUL_EN=0: treated as a single-cycle op with alu_res=0.
- flush=1 at an edge: out_valid to 0, FSM to IDLE, no accept that cycle. A MUL in flight is discarded.
- Control outputs for MUL (out_pc, out_taken, write_data) are computed at accept from the inputs, with alu_res taken as 0 for the jalr target.

Test Plan:
- Reset with out_ready=1, then ADD with rd1=5, imm=3, alu_src=1 -> next cycle out_valid=1, alu_res=8, write_data=rd2.
- jalr with PC_W=5, in_pc=7, rd1=30, imm=4, alu_src=1, jump_type=4'b0011 -> alu_res=34, out_pc=2, out_taken=1, write_data=8.
- jal with in_pc=31, imm=1, jump_type=4'b0010 -> out_pc=0, write_data=0 (PC wrap).
- BNE-style branch with jump_type=4'b1100, rd1=rd2=9 -> out_taken=0; with rd2=10 -> out_taken=1.
- Back-pressure: three ADDs while out_ready=0 after the first -> in_ready=0, first result held stable; releasing out_ready drains results in order, one per cycle.
- MUL (XLEN=32) with rd1=7, rd2=6, alu_src=0 -> in_ready=0 for 32 cycles, then out_valid=1, alu_res=42. Repeat with flush at busy cycle 10 -> no result, in_ready=1 next cycle. Repeat with rst_n=0 mid-MUL -> all outputs 0.
